// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD widths, limits and active-low 7-segment codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [BCD_W-1:0] bcd_saturate(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd7seg.sv
// ============================================================================
// Module      : bcd7seg
// Description : BCD to active-low 7-segment decoder; non-BCD codes blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd7seg
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module      : bcd_digit
// Description : One BCD decade cell: up/down step, clear, saturating load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             clr,
  output logic [BCD_W-1:0] digit,
  output logic             cy
);

  // Carry/borrow is combinational so a full ripple settles within one cycle.
  assign cy = en & (up_dn ? (digit == BCD_MAX) : (digit == '0));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (ld) begin
      digit <= bcd_saturate(ld_val);
    end else if (en) begin
      if (up_dn) begin
        digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
      end else begin
        digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_tick_counter.sv
// ============================================================================
// Module      : bcd_tick_counter
// Description : Prescaled multi-digit BCD up/down counter with wrap carry.
//               Define BCD_SEG_OUT_EN to add the HEX port and 7-seg decoders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    carry_out
`ifdef BCD_SEG_OUT_EN
  ,
  output logic [SEG_W*DIGITS-1:0] HEX
`endif
);

  localparam logic [PRESCALE_W-1:0] TERMINAL = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] prescaler;
  logic                  at_terminal;
  logic                  tick_en;
  logic [DIGITS-1:0]     digit_en;
  logic [DIGITS-1:0]     cy;

  assign at_terminal = (prescaler == TERMINAL);
  // Clear/load on the terminal cycle suppress the count step.
  assign tick_en     = run & at_terminal & ~reset & ~clear & ~load;

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear || load) begin
      prescaler <= '0;
      tick      <= 1'b0;
      carry_out <= 1'b0;
    end else if (run) begin
      if (at_terminal) begin
        prescaler <= '0;
        tick      <= 1'b1;
        carry_out <= cy[DIGITS-1];
      end else begin
        prescaler <= prescaler + PRESCALE_W'(1);
        tick      <= 1'b0;
        carry_out <= 1'b0;
      end
    end else begin
      tick      <= 1'b0;
      carry_out <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      if (k == 0) begin : g_first
        assign digit_en[k] = tick_en;
      end else begin : g_next
        assign digit_en[k] = tick_en & cy[k-1];
      end

      bcd_digit u_digit (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (digit_en[k]),
        .up_dn    (up_dn),
        .ld       (load),
        .ld_val   (load_val[BCD_W*k +: BCD_W]),
        .clr      (clear),
        .digit    (bcd[BCD_W*k +: BCD_W]),
        .cy       (cy[k])
      );

`ifdef BCD_SEG_OUT_EN
      bcd7seg u_seg (
        .bcd (bcd[BCD_W*k +: BCD_W]),
        .seg (HEX[SEG_W*k +: SEG_W])
      );
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bcd_tick_counter.sv
// ============================================================================
// Module      : tb_bcd_tick_counter
// Description : Directed + random bench against a decimal-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_tick_counter;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int MODULUS  = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, run = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] bcd;
  logic       tick, carry_out;
`ifdef BCD_SEG_OUT_EN
  logic [13:0] HEX;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the count is a plain integer, the phase a cycle counter.
  int m_cnt = 0;
  int m_pre = 0;
  bit m_tick = 0;
  bit m_cy = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  bcd_tick_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .PRESCALE_W(3)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .run       (run),
    .up_dn     (up_dn),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .bcd       (bcd),
    .tick      (tick),
    .carry_out (carry_out)
`ifdef BCD_SEG_OUT_EN
    ,
    .HEX       (HEX)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_dec(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic void model_step();
    m_tick = 0;
    m_cy   = 0;
    if (reset || clear) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (load) begin
      m_cnt = sat_dec(load_val[7:4]) * 10 + sat_dec(load_val[3:0]);
      m_pre = 0;
    end else if (run) begin
      if (m_pre == TICK_DIV - 1) begin
        m_pre  = 0;
        m_tick = 1;
        if (up_dn) begin
          m_cy  = (m_cnt == MODULUS - 1);
          m_cnt = (m_cnt + 1) % MODULUS;
        end else begin
          m_cy  = (m_cnt == 0);
          m_cnt = (m_cnt + MODULUS - 1) % MODULUS;
        end
      end else begin
        m_pre++;
      end
    end
  endfunction

  // Apply one cycle of inputs, advance the model, then compare away from the edge.
  task automatic step(input bit rs, input bit cl, input bit ld, input bit rn,
                      input bit ud, input logic [7:0] lv);
    reset = rs; clear = cl; load = ld; run = rn; up_dn = ud; load_val = lv;
    @(posedge CLOCK_50);
    model_step();
    #1;
    check("bcd", 32'(bcd), 32'(to_bcd(m_cnt)));
    check("tick", 32'(tick), 32'(m_tick));
    check("carry_out", 32'(carry_out), 32'(m_cy));
`ifdef BCD_SEG_OUT_EN
    check("hex", 32'(HEX), 32'({seg_of(m_cnt / 10), seg_of(m_cnt % 10)}));
`endif
  endtask

  task automatic run_cycles(input int n, input bit ud);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, ud, 8'h00);
  endtask

  initial begin
    step(1, 0, 0, 0, 1, 8'h00);
    step(1, 0, 0, 0, 1, 8'h00);
    check("reset_bcd", 32'(bcd), 32'h00);

    // Up count across the 09 -> 10 decade carry.
    run_cycles(40, 1);
    check("count40", 32'(bcd), 32'h10);

    // Up wrap from 99.
    step(0, 0, 1, 1, 1, 8'h99);
    run_cycles(4, 1);
    check("wrap_up_bcd", 32'(bcd), 32'h00);
    check("wrap_up_cy", 32'(carry_out), 32'h1);
    run_cycles(4, 1);
    check("no_wrap_cy", 32'(carry_out), 32'h0);

    // Down wrap from 00 then 98, 97.
    step(0, 0, 1, 1, 0, 8'h00);
    run_cycles(4, 0);
    check("wrap_dn_bcd", 32'(bcd), 32'h99);
    check("wrap_dn_cy", 32'(carry_out), 32'h1);
    run_cycles(8, 0);
    check("down_97", 32'(bcd), 32'h97);

    step(0, 0, 1, 0, 1, 8'h3F);
    check("load_sat", 32'(bcd), 32'h39);

    // Pause after two prescaler counts, then resume.
    step(0, 0, 1, 1, 1, 8'h20);
    run_cycles(2, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 8'h00);
    check("pause_hold", 32'(bcd), 32'h20);
    run_cycles(1, 1);
    check("resume_no_tick", 32'(tick), 32'h0);
    run_cycles(1, 1);
    check("resume_tick", 32'(tick), 32'h1);

    // Clear coincident with the terminal count.
    run_cycles(3, 1);
    step(0, 1, 0, 1, 1, 8'h00);
    check("clr_term_tick", 32'(tick), 32'h0);
    run_cycles(3, 1);
    check("clr_early_tick", 32'(tick), 32'h0);
    run_cycles(1, 1);
    check("clr_period_tick", 32'(tick), 32'h1);

    // Reset mid-count.
    step(0, 0, 1, 1, 1, 8'h57);
    run_cycles(2, 1);
    step(1, 0, 0, 1, 1, 8'h00);
    check("rst_mid_bcd", 32'(bcd), 32'h00);

`ifdef BCD_SEG_OUT_EN
    step(0, 0, 1, 0, 1, 8'h42);
    check("hex_42", 32'(HEX), 32'({7'h19, 7'h24}));
`endif

    // Randomized run with sparse clear/load/reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Parametrised multi-digit BCD counter, advanced by an internal prescaled tick (nominally 1 Hz from CLOCK_50).
- Adds the following to the single-digit fixed up-counter: N digits, up/down, run/pause, synchronous clear/load and wrap carry.
- Feeds the board HEX displays, either as a raw BCD bus or, optionally, through built-in 7-seg decoders.

Parameters:
- DIGITS, 4, number of BCD decades (1..8).
- TICK_DIV, 50000000, CLOCK_50 cycles per count tick (>=2).
- PRESCALE_W, 26, prescaler width; must satisfy 2^PRESCALE_W >= TICK_DIV.

Ports:
- CLOCK_50  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler advances; 0 = prescaler and count hold.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clear  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  BCD load value; digit 0 in [3:0].
- bcd  out  4*DIGITS  current count, digit 0 = least significant, in [3:0].
- tick  out  1  one-cycle pulse, coincident with each count update.
- carry_out  out  1  one-cycle pulse on wrap (up 9..9->0..0, down 0..0->9..9).
- HEX  out  7*DIGITS  active-low segments, digit 0 in [6:0]; present only with BCD_SEG_OUT_EN.

Behaviour:
- Clocking and reset: one clock (CLOCK_50); reset is synchronous and active-high.
- Reset values: prescaler=0, bcd=0, tick=0, carry_out=0, HEX = pattern for all digits "0".
- Priority per cycle: reset > clear > load > tick-advance.
- Prescaler:
  - When run=1, increments each cycle.
  - On reaching TICK_DIV-1 it returns to 0, and at that same edge the count updates and tick is registered high for exactly one cycle.
  - When run=0, the prescaler holds and no tick occurs.
  - Tick period is exactly TICK_DIV cycles of continuous run.
- clear: bcd<=0, prescaler<=0, tick=0, carry_out=0 on the next edge.
- load:
  - bcd<=load_val, with any digit > 9 saturated to 9; prescaler<=0; tick=0, carry_out=0.
  - load with run=1 restarts a full TICK_DIV period.
- Count step (on tick edge only):
  - Up: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
  - Down: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
  - Ripple is combinational across all digits inside one cycle, so every digit updates on the same edge.
- Wrap: all-9 up -> all-0, and all-0 down -> all-9, with carry_out=1 on the same cycle as tick; otherwise carry_out=0.
- up_dn change between ticks has no effect until the next tick. Toggling run preserves prescaler phase.
- clear or load coincident with the prescaler terminal: the tick is suppressed (tick=0) and the clear/load wins.
- Latency: no added pipeline. bcd, tick and carry_out all change at the terminal edge; HEX follows bcd combinationally, same cycle.

Optional Feature:
- Macro: BCD_SEG_OUT_EN.
- Defined: HEX port exists. One bcd7seg per digit decodes bcd into active-low segments (0..9 standard patterns). Only 0..9 can occur.
- Undefined: no HEX port and no decoders; the parent instantiates its own bcd7seg from the bcd bus.

Decomposition:
- Shared package bcd_pkg holds:
  - constants BCD_W=4, SEG_W=7, BCD_MAX=4'd9;
  - the active-low segment code constants SEG_0..SEG_9 and SEG_BLANK, shared with bcd7seg.
- Natural sub-module bcd_digit, one decade cell:
  - inputs en, up_dn, ld, ld_val, clr;
  - outputs digit[3:0] and cy (carry when en & up & digit==9, borrow when en & ~up & digit==0).
  - Cells are chained via generate over DIGITS, with en of digit k = tick_en & cy of digit k-1.

Test Plan:
- Bench parameters: DIGITS=2, TICK_DIV=4.
- Reset then run=1, up_dn=1 for 40 cycles -> tick every 4th cycle; bcd steps 00,01,...,09,10; digit carry at 09->10 happens in one edge.
- load_val=8'h99, load pulse, run=1, up -> next tick: bcd=00, tick=1, carry_out=1 same cycle; carry_out=0 on all other ticks.
- load_val=8'h00, up_dn=0 -> ticks give 99, carry_out=1, then 98, 97; load_val=8'h3F -> bcd=39 (digit saturated).
- run dropped for 10 cycles after 2 prescaler counts -> no tick during pause; first tick arrives 2 cycles after run returns; bcd unchanged while paused.
- clear asserted on the prescaler terminal cycle -> bcd=00, tick=0, next tick exactly 4 cycles later; reset mid-count (bcd=57) -> bcd=00, tick=0, carry_out=0 on the next edge.
- With BCD_SEG_OUT_EN, bcd=8'h42 -> HEX[6:0]=SEG_2 and HEX[13:7]=SEG_4 in the same cycle.
